// File: rtl/sram_clear_writer.sv
// Write-side wrapper for a DEPTH x WIDTH SRAM: hardware clear sequence after
// reset or on request, then valid/ready writes and 1-cycle registered reads.
module sram_clear_writer #(
  parameter int                 DEPTH      = 32,
  parameter int                 WIDTH      = 112,
  parameter int                 AW         = 5,
  parameter logic [WIDTH-1:0]   INIT_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             init_done
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;
  logic             rd_accept_s;

  // Next-state, clear counter and the single shared memory write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    case (state_q)
      S_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = INIT_VALUE;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_READY;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d   = cnt_q + AW'(1);
        end
      end
      S_READY: begin
        // A write in the start_clear cycle still commits; the clear overwrites it later.
        mem_we_s = wr_valid;
        if (start_clear) begin
          state_d = S_CLEAR;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = S_READY;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  assign rd_accept_s = rd_en && (state_q == S_READY);

  // Control and read-data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      cnt_q      <= {AW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_q <= mem_q[rd_addr];
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  // Storage array: never touched by reset, read-first against same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign busy      = (state_q == S_CLEAR);
  assign init_done = (state_q == S_READY);
  assign wr_ready  = (state_q == S_READY);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_sram_clear_writer.sv
// Self-checking bench for sram_clear_writer: abstract reference model checked
// every cycle, a vector table, directed clear/reset sequences and random traffic.
module tb_sram_clear_writer;

  localparam int DEPTH = 32;
  localparam int WIDTH = 112;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_clear = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             init_done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_ready = 1'b0;
  int               m_left  = DEPTH;
  logic [WIDTH-1:0] m_rd_data = '0;
  bit               m_rd_valid = 1'b0;

  typedef struct {
    bit               wv;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    bit               re;
    logic [AW-1:0]    ra;
    bit               exp_rv;
    logic [WIDTH-1:0] exp_rd;
  } vec_t;
  vec_t tbl [6];

  sram_clear_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_clear(start_clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    start_clear = 1'b0;
    wr_valid    = 1'b0;
    rd_en       = 1'b0;
  endtask

  // One clock edge: update the model from the applied inputs, then compare.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_ready    = 1'b0;
      m_left     = DEPTH;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
    end else if (!m_ready) begin
      m_mem[DEPTH - m_left] = '0;
      m_left--;
      m_rd_valid = 1'b0;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = m_mem[rd_addr];
      if (wr_valid) m_mem[wr_addr] = wr_data;
      if (start_clear) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
      end
    end
    #1;
    chk("busy", busy, !m_ready);
    chk("init_done", init_done, m_ready);
    chk("wr_ready", wr_ready, m_ready);
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      step();
      chk("rd_known", $isunknown(rd_data), 1'b0);
    end
    idle();
  endtask

  task automatic count_busy(input string name, input int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 40);
    chk(name, n, exp_n);
  endtask

  initial begin
    logic [127:0] rnd;
    int n;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    tbl[0] = '{1'b1, 5'd5, {14{8'hA5}}, 1'b0, 5'd0, 1'b0, 112'h0};
    tbl[1] = '{1'b0, 5'd0, 112'h0, 1'b1, 5'd5, 1'b1, {14{8'hA5}}};
    tbl[2] = '{1'b0, 5'd0, 112'h0, 1'b1, 5'd6, 1'b1, 112'h0};
    tbl[3] = '{1'b1, 5'd3, 112'h1234, 1'b1, 5'd3, 1'b1, 112'h0};
    tbl[4] = '{1'b0, 5'd0, 112'h0, 1'b1, 5'd3, 1'b1, 112'h1234};
    tbl[5] = '{1'b0, 5'd0, 112'h0, 1'b0, 5'd0, 1'b0, 112'h1234};

    // Power-up: 3 reset cycles, then the full clear; reads during clear are ignored.
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    do begin
      rd_en   = 1'b1;
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
      n++;
    end while (busy && n < 40);
    chk("init_len", n, 32);
    read_all();

    // Table-driven write/read vectors.
    for (int i = 0; i < 6; i++) begin
      idle();
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en    = tbl[i].re; rd_addr = tbl[i].ra;
      step();
      chk("tbl_rv", rd_valid, tbl[i].exp_rv);
      chk("tbl_rd", rd_data, tbl[i].exp_rd);
    end

    // Fill with FF, then clear together with a write and a read of addr 9.
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      wr_valid = 1'b1; wr_addr = AW'(a); wr_data = 112'hFF;
      step();
    end
    idle();
    start_clear = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 112'hABC;
    rd_en = 1'b1; rd_addr = 5'd9;
    step();
    chk("preclear_rd", rd_data, 112'hFF);
    rd_en = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 112'h55;
    n = 0;
    do begin
      start_clear = 1'($urandom_range(0, 1));
      step();
      n++;
    end while (busy && n < 40);
    chk("reclear_len", n, 32);
    start_clear = 1'b0;
    rd_en = 1'b0;
    step();
    read_all();
    idle(); rd_en = 1'b1; rd_addr = 5'd9; step();
    chk("addr9_cleared", rd_data, 112'h0);
    idle(); rd_en = 1'b1; rd_addr = 5'd12; step();
    chk("held_write", rd_data, 112'h55);

    // Reset in the middle of a clear (cnt=17), plus a read on the reset edge.
    idle(); wr_valid = 1'b1; wr_addr = 5'd30; wr_data = 112'h7; step();
    idle(); start_clear = 1'b1; step();
    idle();
    repeat (17) step();
    rst_n = 1'b0; rd_en = 1'b1; rd_addr = 5'd30;
    step();
    chk("rst_rv", rd_valid, 1'b0);
    chk("rst_rd", rd_data, 112'h0);
    rst_n = 1'b1; idle();
    count_busy("rst_clear_len", 32);
    idle(); rd_en = 1'b1; rd_addr = 5'd30; step();
    chk("addr30_cleared", rd_data, 112'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 249) != 0);
      start_clear = ($urandom_range(0, 39) == 0);
      wr_valid    = 1'($urandom_range(0, 1));
      wr_addr     = AW'($urandom_range(0, DEPTH - 1));
      rnd         = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr_data     = rnd[WIDTH-1:0];
      rd_en       = 1'($urandom_range(0, 1));
      rd_addr     = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    rst_n = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
